// File: rtl/axi_wr_arb_pkg.sv
// ---------------------------------------------------------------------------
// axi_wr_arb_pkg
//   Shared definitions for the AXI write-channel arbiter:
//   - arb_state_t : FSM state encoding (IDLE, AW, W, B)
//   - DEF_*       : default parameter values
//   - id_width()  : width of a master index, never less than 1 bit
// ---------------------------------------------------------------------------
package axi_wr_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2,
    ST_B    = 2'd3
  } arb_state_t;

  localparam int DEF_NUM_M  = 2;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // $clog2(1) is 0, which would give a zero-width index; clamp to 1.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin picker. Searches req upward starting at
//   rr_ptr, wrapping past NUM_M-1 back to 0, and reports the first set bit.
//   The pointer itself is stored by the parent.
//
// Ports:
//   req     in  NUM_M  request vector
//   rr_ptr  in  ID_W   index with the highest priority this round
//   winner  out ID_W   index of the selected requester (0 when none)
//   any_req out 1      at least one request bit is set
// ---------------------------------------------------------------------------
module rr_arbiter
  import axi_wr_arb_pkg::*;
#(
  parameter int NUM_M = DEF_NUM_M,
  parameter int ID_W  = id_width(NUM_M)
) (
  input  logic [NUM_M-1:0] req,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [ID_W-1:0]  winner,
  output logic             any_req
);

  // cand_idx[k] is the master examined at search offset k from rr_ptr.
  logic [ID_W-1:0]  cand_idx [NUM_M];
  logic [NUM_M-1:0] cand_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_M; gi++) begin : g_cand
      // One extra bit so rr_ptr + offset cannot overflow before the wrap.
      logic [ID_W:0] sum;
      assign sum = {1'b0, rr_ptr} + (ID_W+1)'(gi);
      // Modulo by subtraction: NUM_M need not be a power of two.
      assign cand_idx[gi] = (sum >= (ID_W+1)'(NUM_M)) ?
                            ID_W'(sum - (ID_W+1)'(NUM_M)) : sum[ID_W-1:0];
      assign cand_hit[gi] = req[cand_idx[gi]];
    end
  endgenerate

  // Walk from the farthest offset down so the nearest hit is assigned last.
  always_comb begin
    winner = '0;
    for (int k = NUM_M - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        winner = cand_idx[k];
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/axi_wr_arbiter.sv
// ---------------------------------------------------------------------------
// axi_wr_arbiter
//   Shares one single-beat AXI write slave (the AXI-to-APB bridge) between
//   NUM_M write masters. A master is chosen round-robin from the AW valids,
//   keeps the grant through AW, W and B, and then the FSM always revisits
//   IDLE before the next arbitration. One transaction is in flight at most.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   s_awaddr/s_awvalid      per-master AW (slice i at [i*ADDR_W +: ADDR_W])
//   s_awready               per-master AW ready
//   s_wdata/s_wvalid        per-master W  (slice i at [i*DATA_W +: DATA_W])
//   s_wready                per-master W ready
//   s_bvalid / s_bready     per-master B response
//   m_aw*/m_w*/m_b*         single channel towards the bridge
//   grant_id                current (or last) granted master index
//   busy                    high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module axi_wr_arbiter
  import axi_wr_arb_pkg::*;
#(
  parameter int NUM_M  = DEF_NUM_M,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ID_W   = id_width(NUM_M)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // master side
  input  logic [NUM_M*ADDR_W-1:0]  s_awaddr,
  input  logic [NUM_M-1:0]         s_awvalid,
  output logic [NUM_M-1:0]         s_awready,
  input  logic [NUM_M*DATA_W-1:0]  s_wdata,
  input  logic [NUM_M-1:0]         s_wvalid,
  output logic [NUM_M-1:0]         s_wready,
  output logic [NUM_M-1:0]         s_bvalid,
  input  logic [NUM_M-1:0]         s_bready,
  // bridge side
  output logic [ADDR_W-1:0]        m_awaddr,
  output logic                     m_awvalid,
  input  logic                     m_awready,
  output logic [DATA_W-1:0]        m_wdata,
  output logic                     m_wvalid,
  input  logic                     m_wready,
  input  logic                     m_bvalid,
  output logic                     m_bready,
  // status
  output logic [ID_W-1:0]          grant_id,
  output logic                     busy
);

  arb_state_t       state_reg;
  logic [ID_W-1:0]  grant_reg;
  logic [ID_W-1:0]  rr_ptr_reg;
  logic             busy_reg;

  logic [ID_W-1:0]  winner;
  logic             any_req;
  logic [ID_W-1:0]  ptr_next;

  logic [ADDR_W-1:0] aw_addr_arr [NUM_M];
  logic [DATA_W-1:0] w_data_arr  [NUM_M];
  logic [NUM_M-1:0]  sel;

  logic aw_hs;
  logic w_hs;
  logic b_hs;

  // -------------------------------------------------------------------------
  // Per-master unpacking and ready/valid fan-out. Only the granted master
  // ever sees a ready or a B valid, and only in the matching phase.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_M; gi++) begin : g_master
      assign aw_addr_arr[gi] = s_awaddr[gi*ADDR_W +: ADDR_W];
      assign w_data_arr[gi]  = s_wdata[gi*DATA_W +: DATA_W];
      assign sel[gi]         = (grant_reg == ID_W'(gi));

      assign s_awready[gi] = sel[gi] && (state_reg == ST_AW) && m_awready;
      assign s_wready[gi]  = sel[gi] && (state_reg == ST_W)  && m_wready;
      assign s_bvalid[gi]  = sel[gi] && (state_reg == ST_B)  && m_bvalid;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Bridge-side mux, driven from the registered grant. Address and data read
  // zero outside their own phase so the bridge never sees stale payloads.
  // -------------------------------------------------------------------------
  always_comb begin
    m_awvalid = 1'b0;
    m_awaddr  = '0;
    m_wvalid  = 1'b0;
    m_wdata   = '0;
    m_bready  = 1'b0;
    case (state_reg)
      ST_AW: begin
        m_awvalid = s_awvalid[grant_reg];
        m_awaddr  = aw_addr_arr[grant_reg];
      end
      ST_W: begin
        m_wvalid = s_wvalid[grant_reg];
        m_wdata  = w_data_arr[grant_reg];
      end
      ST_B: begin
        m_bready = s_bready[grant_reg];
      end
      default: begin
      end
    endcase
  end

  // The valids/readys above are already gated by state, so a plain AND
  // identifies the handshake of the active phase.
  assign aw_hs = m_awvalid && m_awready;
  assign w_hs  = m_wvalid  && m_wready;
  assign b_hs  = m_bvalid  && m_bready;

  // Next round starts searching just after the master that was served.
  assign ptr_next = (grant_reg == ID_W'(NUM_M - 1)) ? '0 : grant_reg + ID_W'(1);

  rr_arbiter #(
    .NUM_M (NUM_M),
    .ID_W  (ID_W)
  ) u_rr_arbiter (
    .req     (s_awvalid),
    .rr_ptr  (rr_ptr_reg),
    .winner  (winner),
    .any_req (any_req)
  );

  // -------------------------------------------------------------------------
  // Transaction FSM. The grant is only loaded in IDLE, so it cannot move
  // until the B handshake returns the FSM there. A granted master that drops
  // awvalid simply leaves the FSM parked in AW.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      grant_reg  <= '0;
      rr_ptr_reg <= '0;
      busy_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (any_req) begin
            grant_reg <= winner;
            state_reg <= ST_AW;
            busy_reg  <= 1'b1;
          end
        end
        ST_AW: begin
          if (aw_hs) begin
            state_reg <= ST_W;
          end
        end
        ST_W: begin
          if (w_hs) begin
            state_reg <= ST_B;
          end
        end
        ST_B: begin
          if (b_hs) begin
            rr_ptr_reg <= ptr_next;
            state_reg  <= ST_IDLE;
            busy_reg   <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign grant_id = grant_reg;
  assign busy     = busy_reg;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_wr_arbiter
//   Directed and randomized transactions against axi_wr_arbiter with three
//   masters. The bench plays both the masters and the bridge; the expected
//   winner comes from a simple model (pending flags plus a round-robin
//   pointer), and every phase is checked cycle by cycle.
// ---------------------------------------------------------------------------
module tb_axi_wr_arbiter;
  import axi_wr_arb_pkg::*;

  localparam int NM = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NM*AW-1:0] s_awaddr;
  logic [NM-1:0]   s_awvalid;
  logic [NM-1:0]   s_awready;
  logic [NM*DW-1:0] s_wdata;
  logic [NM-1:0]   s_wvalid;
  logic [NM-1:0]   s_wready;
  logic [NM-1:0]   s_bvalid;
  logic [NM-1:0]   s_bready;
  logic [AW-1:0]   m_awaddr;
  logic            m_awvalid;
  logic            m_awready;
  logic [DW-1:0]   m_wdata;
  logic            m_wvalid;
  logic            m_wready;
  logic            m_bvalid;
  logic            m_bready;
  logic [IW-1:0]   grant_id;
  logic            busy;

  always #5 clk = ~clk;

  axi_wr_arbiter #(
    .NUM_M  (NM),
    .ADDR_W (AW),
    .DATA_W (DW),
    .ID_W   (IW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_awaddr  (s_awaddr),
    .s_awvalid (s_awvalid),
    .s_awready (s_awready),
    .s_wdata   (s_wdata),
    .s_wvalid  (s_wvalid),
    .s_wready  (s_wready),
    .s_bvalid  (s_bvalid),
    .s_bready  (s_bready),
    .m_awaddr  (m_awaddr),
    .m_awvalid (m_awvalid),
    .m_awready (m_awready),
    .m_wdata   (m_wdata),
    .m_wvalid  (m_wvalid),
    .m_wready  (m_wready),
    .m_bvalid  (m_bvalid),
    .m_bready  (m_bready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  int total  = 0;
  int passed = 0;

  // Master-side model state
  bit          aw_pend [NM];
  bit          w_pend  [NM];
  logic [31:0] addr_q  [NM];
  logic [31:0] data_q  [NM];
  int          ptr = 0;
  int          last_grant = 0;
  bit          rand_mode = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive();
    for (int i = 0; i < NM; i++) begin
      s_awvalid[i]            = aw_pend[i];
      s_wvalid[i]             = w_pend[i];
      s_awaddr[i*AW +: AW]    = addr_q[i];
      s_wdata[i*DW +: DW]     = data_q[i];
    end
  endtask

  task automatic new_req(input int i, input logic [31:0] a, input logic [31:0] d);
    aw_pend[i] = 1'b1;
    w_pend[i]  = 1'b1;   // W offered together with AW, before it is granted
    addr_q[i]  = a;
    data_q[i]  = d;
  endtask

  // Random new requests from idle, non-granted masters while a transfer runs.
  task automatic rand_fill(input int excl);
    if (rand_mode) begin
      for (int i = 0; i < NM; i++) begin
        if (i != excl && !aw_pend[i] && !w_pend[i] && $urandom_range(0, 3) == 0)
          new_req(i, $urandom, $urandom);
      end
    end
  endtask

  // Round-robin rule: first pending master at or after ptr, wrapping.
  function automatic int model_pick();
    for (int k = 0; k < NM; k++) begin
      int i;
      i = (ptr + k) % NM;
      if (aw_pend[i]) return i;
    end
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NM; i++) begin
      aw_pend[i] = 1'b0;
      w_pend[i]  = 1'b0;
    end
    drive();
    m_awready = 1'b0;
    m_wready  = 1'b0;
    m_bvalid  = 1'b0;
    ptr = 0;
    last_grant = 0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // One full transaction: IDLE, AW (+aw_w waits), W (+w_w), B (+b_w).
  task automatic do_txn(input int aw_w, input int w_w, input int b_w, input bit rereq);
    int exp;
    logic [NM-1:0] oh;
    exp = model_pick();
    oh  = NM'(1) << exp;

    drive();
    #1;
    chk("idle.busy", busy, 0);
    chk("idle.grant_hold", grant_id, last_grant);
    chk("idle.s_awready", s_awready, 0);
    chk("idle.s_wready", s_wready, 0);
    chk("idle.s_bvalid", s_bvalid, 0);
    chk("idle.m_awvalid", m_awvalid, 0);
    chk("idle.m_wvalid", m_wvalid, 0);
    chk("idle.m_bready", m_bready, 0);
    tick();
    chk("aw.busy", busy, 1);
    chk("aw.grant", grant_id, exp);

    for (int k = 0; k <= aw_w; k++) begin
      m_awready = (k == aw_w);
      rand_fill(exp);
      drive();
      #1;
      chk("aw.m_awvalid", m_awvalid, 1);
      chk("aw.m_awaddr", m_awaddr, addr_q[exp]);
      chk("aw.s_awready", s_awready, (k == aw_w) ? oh : '0);
      chk("aw.s_wready_early", s_wready, 0);
      chk("aw.m_wvalid", m_wvalid, 0);
      chk("aw.grant", grant_id, exp);
      tick();
    end
    m_awready = 1'b0;
    aw_pend[exp] = 1'b0;

    for (int k = 0; k <= w_w; k++) begin
      m_wready = (k == w_w);
      rand_fill(exp);
      drive();
      #1;
      chk("w.busy", busy, 1);
      chk("w.m_wvalid", m_wvalid, 1);
      chk("w.m_wdata", m_wdata, data_q[exp]);
      chk("w.s_wready", s_wready, (k == w_w) ? oh : '0);
      chk("w.s_awready", s_awready, 0);
      chk("w.m_awvalid", m_awvalid, 0);
      chk("w.m_awaddr", m_awaddr, 0);
      tick();
    end
    m_wready = 1'b0;
    w_pend[exp] = 1'b0;

    for (int k = 0; k <= b_w; k++) begin
      m_bvalid = (k == b_w);
      rand_fill(exp);
      drive();
      #1;
      chk("b.busy", busy, 1);
      chk("b.s_bvalid", s_bvalid, (k == b_w) ? oh : '0);
      chk("b.m_bready", m_bready, 1);
      chk("b.m_wvalid", m_wvalid, 0);
      chk("b.m_wdata", m_wdata, 0);
      chk("b.s_wready", s_wready, 0);
      chk("b.grant", grant_id, exp);
      tick();
    end
    m_bvalid = 1'b0;
    ptr = (exp + 1) % NM;
    last_grant = exp;
    $display("txn: master %0d addr %h data %h waits aw=%0d w=%0d b=%0d", exp, addr_q[exp],
             data_q[exp], aw_w, w_w, b_w);
    if (rereq) new_req(exp, $urandom, $urandom);
  endtask

  initial begin
    for (int i = 0; i < NM; i++) begin
      aw_pend[i] = 1'b0;
      w_pend[i]  = 1'b0;
      addr_q[i]  = '0;
      data_q[i]  = '0;
    end
    drive();
    s_bready  = '1;
    m_awready = 1'b0;
    m_wready  = 1'b0;
    m_bvalid  = 1'b0;

    // Reset values
    tick();
    tick();
    chk("rst.busy", busy, 0);
    chk("rst.grant_id", grant_id, 0);
    chk("rst.s_awready", s_awready, 0);
    chk("rst.s_wready", s_wready, 0);
    chk("rst.s_bvalid", s_bvalid, 0);
    chk("rst.m_awvalid", m_awvalid, 0);
    chk("rst.m_wvalid", m_wvalid, 0);
    chk("rst.m_bready", m_bready, 0);
    chk("rst.m_awaddr", m_awaddr, 0);
    chk("rst.m_wdata", m_wdata, 0);
    rst_n = 1'b1;
    tick();

    // Single master, zero-wait bridge
    new_req(0, 32'hDEADBEEF, 32'h12345678);
    do_txn(0, 0, 0, 0);

    // Both masters from reset: m0 then m1
    do_reset();
    new_req(0, 32'h0000_2000, 32'h1111_2222);
    new_req(1, 32'h0000_1000, 32'hA5A5_A5A5);
    do_txn(0, 0, 0, 0);
    do_txn(0, 0, 0, 0);

    // Continuous requests from m0 and m1: alternating grants
    do_reset();
    new_req(0, $urandom, $urandom);
    new_req(1, $urandom, $urandom);
    for (int t = 0; t < 6; t++) do_txn(0, 0, 0, 1);

    // Bridge wait states; W is offered long before the AW handshake
    do_txn(3, 2, 4, 0);
    do_txn(3, 2, 4, 0);

    // Randomized traffic from all masters
    rand_mode = 1;
    for (int t = 0; t < 30; t++) begin
      bit any;
      any = 0;
      for (int i = 0; i < NM; i++) any |= aw_pend[i];
      if (!any) new_req($urandom_range(0, NM - 1), $urandom, $urandom);
      do_txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom_range(0, 1)));
    end
    rand_mode = 0;

    // Reset while in W, then a fresh m1 request
    do_reset();
    new_req(2, 32'h5555_0000, 32'h0BAD_F00D);
    drive();
    tick();                 // IDLE -> AW
    m_awready = 1'b1;
    tick();                 // AW handshake -> W
    m_awready = 1'b0;
    aw_pend[2] = 1'b0;
    drive();
    #1;
    chk("rstw.in_w", m_wvalid, 1);
    chk("rstw.grant_before", grant_id, 2);
    rst_n = 1'b0;
    #1;
    chk("rstw.busy", busy, 0);
    chk("rstw.grant_id", grant_id, 0);
    chk("rstw.m_wvalid", m_wvalid, 0);
    chk("rstw.m_wdata", m_wdata, 0);
    chk("rstw.s_wready", s_wready, 0);
    chk("rstw.m_bready", m_bready, 0);
    w_pend[2] = 1'b0;
    drive();
    ptr = 0;
    last_grant = 0;
    tick();
    rst_n = 1'b1;
    tick();
    new_req(1, 32'h0000_3000, 32'hCAFE_0001);
    do_txn(0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
